// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared definitions for the memory port arbiter: arbiter state
//               encoding and the default data-streak limit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Arbiter states; at most one memory transaction is outstanding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  // Consecutive data grants allowed while a fetch is waiting (legal 1..7).
  localparam int C_MAX_D_STREAK_DEFAULT = 4;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single memory port between an instruction-fetch
//               requester (i_*) and a load/store requester (d_*). Data
//               requests win ties, except that after MAX_D_STREAK back-to-back
//               data grants with a fetch waiting, the fetch is served.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_req/i_addr        - fetch request and address
//               i_ack/i_rdata       - fetch completion pulse and data
//               d_req/d_we/d_addr/d_wdata/d_be - load/store request payload
//               d_ack/d_rdata       - load/store completion pulse and data
//               m_req/m_we/m_addr/m_wdata/m_be - memory request (registered)
//               m_ack/m_rdata       - memory completion pulse and read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int MAX_D_STREAK = C_MAX_D_STREAK_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  // fetch side
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [31:0]   i_rdata,
  // load/store side
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_be,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  // memory side
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_be,
  input  logic          m_ack,
  input  logic [31:0]   m_rdata
);

  localparam logic [2:0] c_max_streak = 3'(MAX_D_STREAK);

  arb_state_t    r_state;
  logic [2:0]    r_streak;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;

  // Data wins a tie unless the waiting fetch has already been passed over
  // MAX_D_STREAK times in a row.
  logic w_grant_d;
  logic w_grant_i;

  assign w_grant_d = d_req && (!i_req || (r_streak != c_max_streak));
  assign w_grant_i = i_req && !w_grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_streak <= 3'd0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_be     <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_state <= ST_BUSY_D;
            r_we    <= d_we;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
            r_be    <= d_be;
            // Only a grant that actually made a fetch wait counts.
            if (!i_req)
              r_streak <= 3'd0;
            else if (r_streak != c_max_streak)
              r_streak <= r_streak + 3'd1;
          end else if (w_grant_i) begin
            r_state  <= ST_BUSY_I;
            r_we     <= 1'b0;
            r_addr   <= i_addr;
            r_wdata  <= 32'd0;
            r_be     <= 4'hF;
            r_streak <= 3'd0;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // Always pass through IDLE, so a request still high in its own
          // ack cycle is not granted twice.
          if (m_ack)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory-side request is a pure decode of the state register and the
  // payload comes only from the grant-time registers.
  assign m_req   = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
  assign m_we    = r_we;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign m_be    = r_be;

  // Acks are steered combinationally; an m_ack while IDLE goes nowhere.
  assign i_ack   = m_ack && (r_state == ST_BUSY_I);
  assign d_ack   = m_ack && (r_state == ST_BUSY_D);
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: per-cycle vector
//               table for single transactions, plus hand-written sequences
//               for streak fairness and reset during a transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ack;
  logic [31:0] m_rdata;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.AW(32), .MAX_D_STREAK(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_be    (d_be),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_be    (m_be),
    .m_ack   (m_ack),
    .m_rdata (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table row = inputs applied for one cycle and the outputs expected
  // during that cycle (before the next rising edge).
  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic        mack;
    logic [31:0] mrd;
    logic        e_mreq;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [31:0] e_mwd;
    logic [3:0]  e_mbe;
    logic        e_iack;
    logic        e_dack;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req   = 1'b0;
    i_addr  = 32'd0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'd0;
    d_wdata = 32'd0;
    d_be    = 4'd0;
    m_ack   = 1'b0;
    m_rdata = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Expected grant order with both requesters always asking: 1=data, 0=fetch.
  logic [9:0] exp_seq;
  logic       got_d;

  initial begin
    rst = 1'b1;
    idle_inputs();
    exp_seq = 10'b1111011110;

    //                 ir    ia            dr    dwe   da            dwd            dbe    mack  mrd             mreq  mwe   maddr         mwd            mbe    iack  dack
    vecs[0]  = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    32'h0,         4'h0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,    32'h0,         4'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h100,    1'b0, 1'b0, 32'h0,    32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,    32'h0,         4'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h100,    1'b0, 1'b0, 32'h0,    32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h100,  32'h0,         4'hF, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h100,    1'b0, 1'b0, 32'h0,    32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h100,  32'h0,         4'hF, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h100,    1'b0, 1'b0, 32'h0,    32'h0,         4'h0, 1'b1, 32'h00500093,  1'b1, 1'b0, 32'h100,  32'h0,         4'hF, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h2000, 32'hDEADBEEF,  4'h3, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,    32'h0,         4'h0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h2000, 32'hDEADBEEF,  4'h3, 1'b0, 32'h0,         1'b1, 1'b1, 32'h2000, 32'hDEADBEEF,  4'h3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h2000, 32'hDEADBEEF,  4'h3, 1'b1, 32'h12345678,  1'b1, 1'b1, 32'h2000, 32'hDEADBEEF,  4'h3, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,    32'h0,         4'h0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h40,   32'h0,         4'hF, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,    32'h0,         4'h0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h40,   32'h0,         4'hF, 1'b1, 32'hCAFEF00D,  1'b1, 1'b0, 32'h40,   32'h0,         4'hF, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,    32'h0,         4'h0, 1'b0, 1'b0};

    // ---- reset state (m_ack high in reset must not leak through) ----
    do_reset();
    @(negedge clk);
    m_ack = 1'b1;
    #1;
    chk("reset_m_req",   {31'd0, m_req}, 32'd0);
    chk("reset_m_we",    {31'd0, m_we},  32'd0);
    chk("reset_m_addr",  m_addr,         32'd0);
    chk("reset_m_wdata", m_wdata,        32'd0);
    chk("reset_m_be",    {28'd0, m_be},  32'd0);
    chk("reset_i_ack",   {31'd0, i_ack}, 32'd0);
    chk("reset_d_ack",   {31'd0, d_ack}, 32'd0);
    m_ack = 1'b0;

    // ---- table-driven single transactions ----
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      i_req   = vecs[v].ir;
      i_addr  = vecs[v].ia;
      d_req   = vecs[v].dr;
      d_we    = vecs[v].dwe;
      d_addr  = vecs[v].da;
      d_wdata = vecs[v].dwd;
      d_be    = vecs[v].dbe;
      m_ack   = vecs[v].mack;
      m_rdata = vecs[v].mrd;
      #1;
      chk($sformatf("v%0d_m_req", v), {31'd0, m_req}, {31'd0, vecs[v].e_mreq});
      chk($sformatf("v%0d_i_ack", v), {31'd0, i_ack}, {31'd0, vecs[v].e_iack});
      chk($sformatf("v%0d_d_ack", v), {31'd0, d_ack}, {31'd0, vecs[v].e_dack});
      if (vecs[v].e_mreq) begin
        chk($sformatf("v%0d_m_we", v),    {31'd0, m_we},  {31'd0, vecs[v].e_mwe});
        chk($sformatf("v%0d_m_addr", v),  m_addr,         vecs[v].e_maddr);
        chk($sformatf("v%0d_m_wdata", v), m_wdata,        vecs[v].e_mwd);
        chk($sformatf("v%0d_m_be", v),    {28'd0, m_be},  {28'd0, vecs[v].e_mbe});
      end
      if (vecs[v].e_iack) chk($sformatf("v%0d_i_rdata", v), i_rdata, vecs[v].mrd);
      if (vecs[v].e_dack) chk($sformatf("v%0d_d_rdata", v), d_rdata, vecs[v].mrd);
    end

    // ---- streak fairness: both requesting, memory acks immediately ----
    do_reset();
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = 32'h111;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h222;
    d_be   = 4'hF;
    m_ack  = 1'b1;
    begin
      int n;
      n = 0;
      for (int c = 0; c < 60 && n < 10; c++) begin
        #1;
        if (i_ack && d_ack) begin
          chk("streak_dual_ack", 32'd1, 32'd0);
        end else if (i_ack || d_ack) begin
          got_d = d_ack;
          chk($sformatf("streak_grant%0d", n), {31'd0, got_d}, {31'd0, exp_seq[9-n]});
          chk($sformatf("streak_addr%0d", n), m_addr, got_d ? 32'h222 : 32'h111);
          n++;
        end
        @(negedge clk);
      end
      if (n < 10) begin
        failures++;
        checks++;
        $display("FAIL streak_timeout actual=%0d required=10 grants", n);
      end
    end

    // ---- reset while BUSY_D with the ack still pending ----
    do_reset();
    @(negedge clk);
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h3000;
    d_wdata = 32'hA5A5A5A5;
    d_be    = 4'hC;
    @(negedge clk);
    #1;
    chk("rstbusy_m_req_before", {31'd0, m_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    m_ack = 1'b1;          // late ack arrives in IDLE
    #1;
    chk("rstbusy_m_req_after", {31'd0, m_req}, 32'd0);
    chk("rstbusy_late_d_ack",  {31'd0, d_ack}, 32'd0);
    chk("rstbusy_late_i_ack",  {31'd0, i_ack}, 32'd0);
    @(negedge clk);
    #1;
    chk("rstbusy_regrant_m_req",  {31'd0, m_req}, 32'd1);
    chk("rstbusy_regrant_m_addr", m_addr,         32'h3000);
    chk("rstbusy_regrant_d_ack",  {31'd0, d_ack}, 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rstbusy_done_m_req", {31'd0, m_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
